// File: rtl/booth_mac_pkg.sv
// booth_mac_pkg: shared FSM states, default widths and extend/overflow helpers for the product accumulator
package booth_mac_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam int DEF_PROD_W = 32;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_CNT_W = 8;
  localparam int EXT_W = 128;
  // Sign- or zero-extends the low w bits of v; callers cast the result down to their width.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] v, input int w, input logic s);
    logic [EXT_W-1:0] m;
    m = {EXT_W{1'b1}} << w;
    return (s && v[7'(w - 1)]) ? (v | m) : (v & ~m);
  endfunction
  // Signed: operands agree in sign but the sum does not. Unsigned: carry out of the MSB.
  function automatic logic ovf_detect(input logic a, input logic b, input logic s, input logic c, input logic mode);
    return mode ? (a == b) && (s != a) : c;
  endfunction
endpackage

// File: rtl/booth_prod_accum_if.sv
// booth_prod_accum_if: product-beat input and accumulated-result output handshakes
//   slave modport = accumulator side, master modport = producer/consumer side
interface booth_prod_accum_if
  import booth_mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) ();
  logic in_valid, in_ready, prod_signed, prod_neg, prod_zero, acc_clear;
  logic [PROD_W-1:0] prod_result;
  logic [CNT_W-1:0] acc_len;
  logic out_valid, out_ready, acc_neg, acc_zero, acc_ovf, busy;
  logic [ACC_W-1:0] acc_result;
  modport slave (
    input in_valid, prod_result, prod_signed, prod_neg, prod_zero, acc_len, acc_clear, out_ready,
    output in_ready, out_valid, acc_result, acc_neg, acc_zero, acc_ovf, busy
  );
  modport master (
    output in_valid, prod_result, prod_signed, prod_neg, prod_zero, acc_len, acc_clear, out_ready,
    input in_ready, out_valid, acc_result, acc_neg, acc_zero, acc_ovf, busy
  );
endinterface

// File: rtl/booth_acc_adder.sv
// booth_acc_adder: combinational ACC_W adder with mode-dependent overflow flag
//   a, b: operands; mode: 1 signed / 0 unsigned; sum: wrapped sum; ovf: overflow for this add
module booth_acc_adder
  import booth_mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             mode,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic c;
  always_comb begin
    {c, sum} = {1'b0, a} + {1'b0, b};
    ovf = ovf_detect(a[ACC_W-1], b[ACC_W-1], sum[ACC_W-1], c, mode);
  end
endmodule

// File: rtl/booth_prod_accum.sv
// booth_prod_accum: accumulates a programmable number of multiplier products and hands out the block sum
//   clk, rst (async, active high); bus: slave side of booth_prod_accum_if (beat in, result out)
module booth_prod_accum
  import booth_mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  booth_prod_accum_if.slave bus
);
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc_q, addend, sum;
  logic [CNT_W:0] cnt_q, cnt_nxt, len_q, len_new;
  logic mode_q, ovf_q, add_ovf, first, eff_mode, accept, done;
  assign first = state == IDLE;
  // The first beat of a block chooses the mode; afterwards the latched one rules.
  assign eff_mode = first ? bus.prod_signed : mode_q;
  assign accept = bus.in_valid && bus.in_ready;
  assign done = bus.out_valid && bus.out_ready;
  assign len_new = (bus.acc_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, bus.acc_len};
  assign cnt_nxt = cnt_q + (CNT_W + 1)'(1);
  assign addend = bus.prod_zero ? '0 : ACC_W'(ext(EXT_W'(bus.prod_result), PROD_W, eff_mode));
  // acc, cnt and ovf are always zero in IDLE, so the first beat needs no special adder path.
  booth_acc_adder #(.ACC_W(ACC_W)) u_add (
    .a(acc_q),
    .b(addend),
    .mode(eff_mode),
    .sum(sum),
    .ovf(add_ovf)
  );
  always_comb begin
    state_nxt = bus.acc_clear ? IDLE :
                done ? IDLE :
                (accept && cnt_nxt == (first ? len_new : len_q)) ? HOLD :
                (accept && first) ? ACCUM : state;
    bus.in_ready = (state != HOLD) && !bus.acc_clear;
    bus.out_valid = state == HOLD;
    bus.busy = state != IDLE;
    bus.acc_result = acc_q;
    bus.acc_neg = mode_q && acc_q[ACC_W-1];
    bus.acc_zero = acc_q == '0;
    bus.acc_ovf = ovf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.acc_clear || done) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (accept) begin
        acc_q <= sum;
        cnt_q <= cnt_nxt;
        ovf_q <= ovf_q || add_ovf;
        if (first) begin
          len_q <= len_new;
          mode_q <= bus.prod_signed;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_prod_accum.sv
// tb_booth_prod_accum: directed vector bench for booth_prod_accum (40-bit and 34-bit accumulators)
module tb_booth_prod_accum;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  booth_prod_accum_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) i0 ();
  booth_prod_accum_if #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) i1 ();
  booth_prod_accum #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  booth_prod_accum #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  always #5 clk = ~clk;
  typedef struct {
    int len;
    logic [3:0][31:0] p;
    logic [3:0] sf;
    logic [3:0] zf;
    logic [39:0] res;
    logic neg;
    logic zero;
    logic ovf;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic drive(input int d, input logic v, input logic [31:0] p, input logic s, input logic z);
    if (d == 0) begin
      i0.in_valid = v; i0.prod_result = p; i0.prod_signed = s; i0.prod_zero = z;
    end else begin
      i1.in_valid = v; i1.prod_result = p; i1.prod_signed = s; i1.prod_zero = z;
    end
  endtask
  task automatic beat(input int d, input logic [31:0] p, input logic s, input logic z);
    logic rdy;
    drive(d, 1'b1, p, s, z);
    rdy = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      rdy = (d == 0) ? i0.in_ready : i1.in_ready;
      if (rdy) break;
      @(negedge clk);
    end
    chk("beat_ready", 64'(rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    drive(d, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask
  task automatic pop(input int d);
    if (d == 0) i0.out_ready = 1'b1; else i1.out_ready = 1'b1;
    @(negedge clk);
    chk("pop_busy", 64'((d == 0) ? i0.busy : i1.busy), 64'd0);
    chk("pop_valid", 64'((d == 0) ? i0.out_valid : i1.out_valid), 64'd0);
    i0.out_ready = 1'b0;
    i1.out_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{3, {32'd0, 32'd65534, 32'd30, 32'hFFFFFFDC}, 4'b0111, 4'b0000, 40'd65528, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2, {32'd0, 32'd0, 32'd6, 32'hFFFFFFDC}, 4'b0011, 4'b0000, 40'hFFFFFFFFE2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2, {32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0000, 4'b0000, 40'h1FFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3, {32'd0, 32'd7, 32'd100, 32'd5}, 4'b0111, 4'b0010, 40'd12, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2, {32'd0, 32'd0, 32'hFFFFFFFF, 32'd1}, 4'b0010, 4'b0000, 40'h100000000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1, {32'd0, 32'd0, 32'd0, 32'd7}, 4'b0001, 4'b0000, 40'd7, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2, {32'd0, 32'd0, 32'hFFFFFFFB, 32'd5}, 4'b0011, 4'b0000, 40'd0, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
    i0.prod_neg = 1'b0; i0.acc_len = '0; i0.acc_clear = 1'b0; i0.out_ready = 1'b0;
    i1.prod_neg = 1'b0; i1.acc_len = '0; i1.acc_clear = 1'b0; i1.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(i0.out_valid), 64'd0);
    chk("rst_acc_result", 64'(i0.acc_result), 64'd0);
    chk("rst_acc_neg", 64'(i0.acc_neg), 64'd0);
    chk("rst_acc_zero", 64'(i0.acc_zero), 64'd1);
    chk("rst_acc_ovf", 64'(i0.acc_ovf), 64'd0);
    chk("rst_busy", 64'(i0.busy), 64'd0);
    chk("rst_in_ready", 64'(i0.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 7; v++) begin
      i0.acc_len = 8'(vecs[v].len);
      for (int b = 0; b < vecs[v].len; b++) begin
        beat(0, vecs[v].p[b], vecs[v].sf[b], vecs[v].zf[b]);
        if (b < vecs[v].len - 1) chk("mid_out_valid", 64'(i0.out_valid), 64'd0);
      end
      chk($sformatf("v%0d_out_valid", v), 64'(i0.out_valid), 64'd1);
      chk($sformatf("v%0d_in_ready", v), 64'(i0.in_ready), 64'd0);
      chk($sformatf("v%0d_result", v), 64'(i0.acc_result), 64'(vecs[v].res));
      chk($sformatf("v%0d_neg", v), 64'(i0.acc_neg), 64'(vecs[v].neg));
      chk($sformatf("v%0d_zero", v), 64'(i0.acc_zero), 64'(vecs[v].zero));
      chk($sformatf("v%0d_ovf", v), 64'(i0.acc_ovf), 64'(vecs[v].ovf));
      pop(0);
    end
    // 34-bit unsigned wrap: 5 x 0xFFFE0001 exceeds 2^34 on the last beat.
    i1.acc_len = 8'd5;
    for (int b = 0; b < 5; b++) beat(1, 32'hFFFE0001, 1'b0, 1'b0);
    chk("w34u_valid", 64'(i1.out_valid), 64'd1);
    chk("w34u_result", 64'(i1.acc_result), 64'd4294311941);
    chk("w34u_ovf", 64'(i1.acc_ovf), 64'd1);
    chk("w34u_neg", 64'(i1.acc_neg), 64'd0);
    pop(1);
    chk("w34u_ovf_cleared", 64'(i1.acc_ovf), 64'd0);
    // 34-bit signed overflow: 5 x (2^31-1) passes 2^33-1.
    for (int b = 0; b < 5; b++) beat(1, 32'h7FFFFFFF, 1'b1, 1'b0);
    chk("w34s_result", 64'(i1.acc_result), 64'd10737418235);
    chk("w34s_ovf", 64'(i1.acc_ovf), 64'd1);
    chk("w34s_neg", 64'(i1.acc_neg), 64'd1);
    pop(1);
    // acc_len=0 means 256 beats; changing acc_len mid-block has no effect.
    i0.acc_len = 8'd0;
    for (int b = 0; b < 256; b++) begin
      beat(0, 32'd1, 1'b0, 1'b0);
      if (b == 0) i0.acc_len = 8'd3;
      if (b == 254) chk("len256_not_yet", 64'(i0.out_valid), 64'd0);
    end
    chk("len256_valid", 64'(i0.out_valid), 64'd1);
    chk("len256_result", 64'(i0.acc_result), 64'd256);
    drive(0, 1'b1, 32'd1, 1'b0, 1'b0);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(i0.in_ready), 64'd0);
      chk("hold_valid", 64'(i0.out_valid), 64'd1);
      chk("hold_result", 64'(i0.acc_result), 64'd256);
    end
    drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
    pop(0);
    chk("len256_cleared", 64'(i0.acc_result), 64'd0);
    // Abort mid-block with a beat on the bus.
    i0.acc_len = 8'd4;
    beat(0, 32'd10, 1'b0, 1'b0);
    beat(0, 32'd20, 1'b0, 1'b0);
    chk("clr_partial", 64'(i0.acc_result), 64'd30);
    drive(0, 1'b1, 32'd30, 1'b0, 1'b0);
    i0.acc_clear = 1'b1;
    #1;
    chk("clr_in_ready", 64'(i0.in_ready), 64'd0);
    @(negedge clk);
    i0.acc_clear = 1'b0;
    drive(0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("clr_busy", 64'(i0.busy), 64'd0);
    chk("clr_result", 64'(i0.acc_result), 64'd0);
    i0.acc_len = 8'd1;
    beat(0, 32'd7, 1'b0, 1'b0);
    chk("clr_fresh_valid", 64'(i0.out_valid), 64'd1);
    chk("clr_fresh_result", 64'(i0.acc_result), 64'd7);
    // Asynchronous reset while holding a result.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(i0.out_valid), 64'd0);
    chk("arst_result", 64'(i0.acc_result), 64'd0);
    chk("arst_zero", 64'(i0.acc_zero), 64'd1);
    chk("arst_busy", 64'(i0.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_prod_accum.md
Name: booth_prod_accum

Overview:
- Downstream consumer of the combinational booth16x16_top multiplier.
- Registers each PROD_RESULT (with its neg/zero flags and signed mode) under a valid/ready handshake.
- Sums a programmable number of products into a wide accumulator and presents the block result with output flags under a second valid/ready handshake.
- Turns the single-cycle multiplier into a MAC unit for dot-product style operations.

Parameters:
- PROD_W, 32, product width; must match multiplier PROD_RESULT width.
- ACC_W, 40, accumulator width, ACC_W > PROD_W.
- CNT_W, 8, width of the block-length field and beat counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block accepts a beat.
- prod_result  input  PROD_W  multiplier PROD_RESULT.
- prod_signed  input  1  alu_signed used for this product.
- prod_neg  input  1  multiplier neg_flag; monitored only.
- prod_zero  input  1  multiplier zero_flag; a zero beat skips the add but counts.
- acc_len  input  CNT_W  products per block; sampled on the first beat; 0 means 2^CNT_W.
- acc_clear  input  1  synchronous abort/clear.
- out_valid  output  1  accumulated result valid.
- out_ready  input  1  consumer takes the result.
- acc_result  output  ACC_W  accumulated sum.
- acc_neg  output  1  acc_result[ACC_W-1] when the block was signed, else 0.
- acc_zero  output  1  acc_result == 0.
- acc_ovf  output  1  sticky overflow for the block.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; accumulator, counter, mode and ovf cleared.
  - Outputs: out_valid=0, acc_result=0, acc_neg=0, acc_zero=1, acc_ovf=0, busy=0, in_ready=1.
- Beat acceptance: a beat is accepted on a clk edge when in_valid && in_ready.
- in_ready = (state != HOLD) && !acc_clear.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE, first accepted beat:
    - latch len = (acc_len==0 ? 2^CNT_W : acc_len) and mode = prod_signed;
    - acc <= ext(prod_result); cnt <= 1;
    - go HOLD if len==1, else ACCUM.
  - ACCUM, each accepted beat: acc <= acc + ext(prod_result); cnt <= cnt+1. Go HOLD when the incremented cnt == len.
  - HOLD: out_valid=1. acc_result, acc_neg, acc_zero and acc_ovf are stable until out_ready. On out_valid && out_ready go IDLE and clear acc, cnt, ovf.
- Latency: out_valid asserts the cycle after the final beat is accepted. Max throughput is one beat per cycle; one bubble cycle (HOLD) per block minimum.
- Extension rule, ext():
  - mode=1: sign-extend prod_result to ACC_W.
  - mode=0: zero-extend.
  - Mode latched on the first beat governs the whole block; prod_signed on later beats is ignored.
- Zero beat: if prod_zero=1 the adder input is forced to 0; the beat still counts.
- Overflow, sticky until block end, result wraps modulo 2^ACC_W:
  - mode=0: carry out of bit ACC_W-1 sets ovf.
  - mode=1: both operands have the same sign and the sum sign differs, sets ovf.
- acc_clear: highest priority in any state.
  - The next state is IDLE; accumulator, counter and ovf clear; out_valid drops next cycle.
  - A beat presented in the same cycle is not accepted (in_ready=0).
- out_ready while not HOLD is ignored. in_valid in HOLD is back-pressured; there is no simultaneous accept and output.
- acc_len changes after the first beat have no effect on the current block.

Decomposition:
- Shared package booth_mac_pkg holds:
  - state enum (IDLE/ACCUM/HOLD);
  - default widths PROD_W/ACC_W/CNT_W;
  - ext function (sign/zero extend);
  - overflow-detect function.
- One natural sub-module: booth_acc_adder, a combinational ACC_W adder returning {sum, ovf} given mode.
- The FSM, counter and output registers stay in the top.

Test Plan:
- Signed block, acc_len=3, beats -36, 30, 65534 (32767*2), mode=1, out_ready=1 -> out_valid one cycle after the third beat; acc_result=65528, acc_neg=0, acc_zero=0, acc_ovf=0.
- Signed block, acc_len=2, beats -12*3=-36 and -15*2... use beats -36, 6 -> acc_result = 2^40-30 (0xFFFFFFFFE2), acc_neg=1.
- ACC_W=34, unsigned, acc_len=5, five beats 0xFFFE0001 -> acc_result=4294311941 (wrapped), acc_ovf=1, acc_neg=0.
- acc_len=0, 256 beats of value 1 -> acc_result=256 after the 256th beat; in_ready stays 0 while out_ready is held low for 10 cycles; result stays stable.
- acc_clear asserted mid-block after 2 of 4 beats (in_valid high that cycle) -> beat not taken, busy=0 next cycle; a fresh block with acc_len=1 and beat 7 gives 7.
- rst asserted asynchronously in HOLD with out_valid=1 -> out_valid=0, acc_result=0, acc_zero=1 immediately, without waiting for a clk edge.
